neuron_out_backprop: RTL and testbench
======================================

Name: neuron_out_backprop

Overview:
- Backward-pass counterpart of the 14-input output neuron.
- From the neuron's sigmoid output y and target t, it computes the output delta = (t-y)·y·(1-y).
- It then sequentially updates all input weights, w_i += eta·delta·x_i, using one shared multiplier.
- Sits between the forward neuron (supplies x, w, y) and the weight store; the delta output feeds hidden-layer error propagation.

Parameters:
- N_IN, 14, number of inputs/weights.
- W, 17, word width; all data words are signed two's complement.
- FRAC, 12, fractional bits (Q4.12; 1.0 = 4096).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request, honoured only in IDLE
- y  in  W  forward neuron output (sigmoid, 0..4096)
- t  in  W  target value
- eta  in  W  learning rate
- x  in  W*N_IN  packed inputs; x_i = x[W*(i+1)-1:W*i]
- w_in  in  W*N_IN  packed current weights, same packing
- w_out  out  W*N_IN  packed updated weights
- delta  out  W  computed output delta
- delta_valid  out  1  one-cycle pulse when delta is updated
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse; w_out valid from this cycle

Behaviour:
- Reset (async, rst_n=0): state=IDLE; w_out, delta, delta_valid, busy, done and all internal registers = 0.
- Reset mid-operation aborts immediately; no done pulse is produced.
- All registers update on the rising edge of clk. The cycle in which start is sampled is cycle 0.
- IDLE: on start=1, latch y, t, eta, x, w_in into internal registers and go to ERR. Later changes on these inputs have no effect.
- ERR (cycle 1): e = t - y, 18-bit signed. Go to DERIV.
- DERIV (cycle 2): d = (y·(4096-y)) >>> FRAC. Go to DELTA.
- DELTA (cycle 3): delta = sat17((e·d) >>> FRAC). Go to SCALE.
- SCALE (cycle 4): delta_valid=1 for this cycle only. g = sat17((eta·delta) >>> FRAC). Index i=0. Go to UPDATE.
- UPDATE (cycles 5..N_IN+4): one weight per cycle, w_reg[i] = sat17(w_reg[i] + ((g·x_i) >>> FRAC)), then i++. After i = N_IN-1, go to DONE.
- DONE (cycle N_IN+5, cycle 19 at default): done=1, w_out = w_reg. Return to IDLE next cycle.
- w_out holds its value until the next DONE or reset.
- Shift semantics: >>> is an arithmetic shift (truncation toward -inf).
- Saturation: sat17 clamps to [-65536, 65535]. Full-precision products are formed before shift and saturation.
- start while busy=1 is ignored, with no queuing. start in the DONE cycle is also ignored.
- A new start is accepted in the first IDLE cycle after DONE.
- Exactly one multiplier is used; no multi-cycle paths.

Optional Feature:
- Macro NEURON_BP_ROUND_EN.
- Defined: every ">>> FRAC" becomes round-half-up, i.e. add 2^(FRAC-1) to the full-precision product before the shift, then saturate.
- Undefined: plain truncation as above.
- Latency is identical in both cases.

Test Plan:
- Nominal update: y=2048, t=4096, eta=4096, x0=4096, x1=-4096, x2..13=0, w_in=0, start in cycle 0 → delta=512 with delta_valid in cycle 4; done in cycle 19; w0=512, w1=-512, w2..13=0; busy high in cycles 1..19.
- Zero error: y=t=3000, arbitrary x/w_in → delta=0, w_out==w_in bit-exact.
- Saturated sigmoid: y=0, t=4096 → d=0, delta=0, w_out==w_in.
- Weight saturation: y=2048, t=4096, eta=4096, x0=65535, w0=65535 → increment 8191, w0 clamps to 65535. Same case with x0=-65536, w0=-65536 → w0 clamps to -65536.
- Control:
  - start pulsed in cycles 3 and 10 → ignored; single done in cycle 19.
  - rst_n low in cycle 8 → busy=0, w_out=0, no done.
  - Fresh start afterwards completes normally.
- Rounding (with vs without NEURON_BP_ROUND_EN): y=2048, t=2051, eta=4096 → delta=0 without macro, delta=1 with macro.

Source files
------------

// File: rtl/neuron_out_backprop.sv
// rtl/neuron_out_backprop.sv - output-neuron delta and sequential weight update, one shared multiplier
// Optional round-half-up on every Q4.12 rescale: define NEURON_BP_ROUND_EN.
module neuron_out_backprop #(
   parameter int N_IN = 14,
   parameter int W    = 17,
   parameter int FRAC = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [W-1:0]      y,
   input  logic [W-1:0]      t,
   input  logic [W-1:0]      eta,
   input  logic [W*N_IN-1:0] x,
   input  logic [W*N_IN-1:0] w_in,
   output logic [W*N_IN-1:0] w_out,
   output logic [W-1:0]      delta,
   output logic              delta_valid,
   output logic              busy,
   output logic              done
);

   localparam int EW = W + 1;
   localparam int DW = W + 6;
   localparam int MW = W + 8;
   localparam int PW = 2 * MW;
   localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;

   localparam logic signed [EW-1:0] ONE     = EW'(1 << FRAC);
   localparam logic signed [PW-1:0] SAT_MAX = PW'((2 ** (W - 1)) - 1);
   localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - PW'(1);
   localparam logic signed [PW-1:0] HALF    = PW'(1 << (FRAC - 1));
   localparam logic [IW-1:0]        LAST    = IW'(N_IN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ERR,
      S_DERIV,
      S_DELTA,
      S_SCALE,
      S_UPDATE,
      S_DONE
   } state_t;

   state_t                 state_q;
   logic signed [W-1:0]    y_q, t_q, eta_q;
   logic signed [W-1:0]    x_q     [N_IN];
   logic signed [W-1:0]    w_q     [N_IN];
   logic signed [W-1:0]    w_out_q [N_IN];
   logic signed [EW-1:0]   e_q;
   logic signed [DW-1:0]   d_q;
   logic signed [W-1:0]    delta_q;
   logic signed [W-1:0]    g_q;
   logic [IW-1:0]          idx_q;
   logic                   delta_valid_q, busy_q, done_q;

   logic signed [EW-1:0]   one_minus_y;
   logic signed [MW-1:0]   mul_a, mul_b;
   logic signed [PW-1:0]   prod, prod_sh, w_sum_d;
   logic signed [W-1:0]    w_upd_d, prod_sat_d;

   function automatic logic signed [PW-1:0] frac_shift(input logic signed [PW-1:0] p);
`ifdef NEURON_BP_ROUND_EN
      frac_shift = (p + HALF) >>> FRAC;
`else
      frac_shift = p >>> FRAC;
`endif
   endfunction

   function automatic logic signed [W-1:0] sat_w(input logic signed [PW-1:0] v);
      if (v > SAT_MAX)      sat_w = SAT_MAX[W-1:0];
      else if (v < SAT_MIN) sat_w = SAT_MIN[W-1:0];
      else                  sat_w = v[W-1:0];
   endfunction

   assign one_minus_y = ONE - EW'(y_q);

   // Operand steering for the single multiplier; each state owns it for one cycle.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (state_q)
         S_DERIV: begin
            mul_a = MW'(y_q);
            mul_b = MW'(one_minus_y);
         end
         S_DELTA: begin
            mul_a = MW'(e_q);
            mul_b = MW'(d_q);
         end
         S_SCALE: begin
            mul_a = MW'(eta_q);
            mul_b = MW'(delta_q);
         end
         S_UPDATE: begin
            mul_a = MW'(g_q);
            mul_b = MW'(x_q[idx_q]);
         end
         default: ;
      endcase
   end

   assign prod       = mul_a * mul_b;
   assign prod_sh    = frac_shift(prod);
   assign prod_sat_d = sat_w(prod_sh);
   assign w_sum_d    = PW'(w_q[idx_q]) + prod_sh;
   assign w_upd_d    = sat_w(w_sum_d);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         y_q           <= '0;
         t_q           <= '0;
         eta_q         <= '0;
         e_q           <= '0;
         d_q           <= '0;
         delta_q       <= '0;
         g_q           <= '0;
         idx_q         <= '0;
         delta_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         for (int j = 0; j < N_IN; j++) begin
            x_q[j]     <= '0;
            w_q[j]     <= '0;
            w_out_q[j] <= '0;
         end
      end else begin
         delta_valid_q <= 1'b0;
         done_q        <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  y_q    <= y;
                  t_q    <= t;
                  eta_q  <= eta;
                  for (int j = 0; j < N_IN; j++) begin
                     x_q[j] <= x[W*j +: W];
                     w_q[j] <= w_in[W*j +: W];
                  end
                  busy_q  <= 1'b1;
                  state_q <= S_ERR;
               end
            end
            S_ERR: begin
               e_q     <= EW'(t_q) - EW'(y_q);
               state_q <= S_DERIV;
            end
            S_DERIV: begin
               d_q     <= prod_sh[DW-1:0];
               state_q <= S_DELTA;
            end
            S_DELTA: begin
               delta_q       <= prod_sat_d;
               delta_valid_q <= 1'b1;
               state_q       <= S_SCALE;
            end
            S_SCALE: begin
               g_q     <= prod_sat_d;
               idx_q   <= '0;
               state_q <= S_UPDATE;
            end
            S_UPDATE: begin
               w_q[idx_q] <= w_upd_d;
               idx_q      <= idx_q + IW'(1);
               if (idx_q == LAST) begin
                  // Publish with the final weight merged in, since w_q lands on the same edge.
                  for (int j = 0; j < N_IN; j++) begin
                     w_out_q[j] <= (IW'(j) == idx_q) ? w_upd_d : w_q[j];
                  end
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_out = '0;
      for (int j = 0; j < N_IN; j++) begin
         w_out[W*j +: W] = w_out_q[j];
      end
   end

   assign delta       = delta_q;
   assign delta_valid = delta_valid_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_neuron_out_backprop.sv
// tb/tb_neuron_out_backprop.sv - scoreboard bench for neuron_out_backprop
module tb_neuron_out_backprop;

   localparam int N_IN = 14;
   localparam int W    = 17;
   localparam int VW   = W * N_IN;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  y = '0, t = '0, eta = '0;
   logic [VW-1:0] x = '0, w_in = '0;
   logic [VW-1:0] w_out;
   logic [W-1:0]  delta;
   logic          delta_valid, busy, done;

   int checks = 0;
   int errors = 0;

   logic [W-1:0]  exp_delta_q [$];
   logic [VW-1:0] exp_w_q     [$];

   neuron_out_backprop dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .y           (y),
      .t           (t),
      .eta         (eta),
      .x           (x),
      .w_in        (w_in),
      .w_out       (w_out),
      .delta       (delta),
      .delta_valid (delta_valid),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic longint shr(input longint p);
`ifdef NEURON_BP_ROUND_EN
      return (p + 2048) >>> 12;
`else
      return p >>> 12;
`endif
   endfunction

   function automatic longint sat(input longint v);
      if (v > 65535)  return 65535;
      if (v < -65536) return -65536;
      return v;
   endfunction

   task automatic model(input logic [W-1:0] yv, tv, ev, input logic [VW-1:0] xv, wv,
                        output logic [W-1:0] dlt, output logic [VW-1:0] wo);
      longint yy, e, d, dl, g, wi;
      yy = longint'($signed(yv));
      e  = longint'($signed(tv)) - yy;
      d  = shr(yy * (4096 - yy));
      dl = sat(shr(e * d));
      g  = sat(shr(longint'($signed(ev)) * dl));
      dlt = dl[W-1:0];
      wo  = '0;
      for (int i = 0; i < N_IN; i++) begin
         wi = sat(longint'($signed(wv[W*i +: W])) + shr(g * longint'($signed(xv[W*i +: W]))));
         wo[W*i +: W] = wi[W-1:0];
      end
   endtask

   // Scoreboard: every delta_valid / done pulse must match a queued expectation.
   always @(negedge clk) begin
      if (rst_n && delta_valid) begin
         if (exp_delta_q.size() == 0) check_eq("delta_unexpected", VW'(delta_valid), '0);
         else                         check_eq("delta", VW'(delta), VW'(exp_delta_q.pop_front()));
      end
      if (rst_n && done) begin
         if (exp_w_q.size() == 0) check_eq("done_unexpected", VW'(done), '0);
         else                     check_eq("w_out", w_out, exp_w_q.pop_front());
      end
   end

   // Called right after a negedge; start is sampled at the next posedge (cycle 0).
   task automatic run_op(input logic [W-1:0] yv, tv, ev, input logic [VW-1:0] xv, wv,
                         input int abort_cyc, input bit stray, input bit chain);
      logic [W-1:0]  ed;
      logic [VW-1:0] ew;
      int            last_c;
      model(yv, tv, ev, xv, wv, ed, ew);
      exp_delta_q.push_back(ed);
      if (abort_cyc == 0) exp_w_q.push_back(ew);
      y = yv; t = tv; eta = ev; x = xv; w_in = wv;
      start = 1'b1;
      last_c = chain ? N_IN + 6 : N_IN + 8;
      for (int c = 1; c <= last_c; c++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         y = ~yv; t = ~tv; eta = ~ev; x = ~xv; w_in = ~wv;
         @(negedge clk);
         check_eq("busy_t", VW'(busy), VW'(c <= N_IN + 5));
         check_eq("delta_valid_t", VW'(delta_valid), VW'(c == 4));
         check_eq("done_t", VW'(done), VW'(c == N_IN + 5));
         if (c == abort_cyc) begin
            rst_n = 1'b0;
            #1;
            check_eq("abort_busy", VW'(busy), '0);
            check_eq("abort_done", VW'(done), '0);
            check_eq("abort_w_out", w_out, '0);
            check_eq("abort_delta", VW'(delta), '0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            for (int k = 0; k < N_IN + 8; k++) begin
               @(negedge clk);
               check_eq("post_abort_busy", VW'(busy), '0);
            end
            break;
         end
         start = stray && (c == 3 || c == 10 || c == N_IN + 5);
      end
      start = 1'b0;
   endtask

   task automatic rand_vec(output logic [VW-1:0] v);
      for (int i = 0; i < N_IN; i++) v[W*i +: W] = W'($urandom);
   endtask

   logic [VW-1:0] xv, wv;
   logic [W-1:0]  rnd_exp;

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", VW'(busy), '0);
      check_eq("rst_done", VW'(done), '0);
      check_eq("rst_dv", VW'(delta_valid), '0);
      check_eq("rst_delta", VW'(delta), '0);
      check_eq("rst_w_out", w_out, '0);
      rst_n = 1'b1;
      @(negedge clk);

      // Nominal update
      xv = '0; wv = '0;
      xv[W-1:0]   = 17'd4096;
      xv[2*W-1:W] = 17'h1F000;
      run_op(17'd2048, 17'd4096, 17'd4096, xv, wv, 0, 1'b0, 1'b0);
      check_eq("nom_delta", VW'(delta), VW'(17'd512));
      check_eq("nom_w0", VW'(w_out[W-1:0]), VW'(17'd512));
      check_eq("nom_w1", VW'(w_out[2*W-1:W]), VW'(17'h1FE00));
      check_eq("nom_w_rest", VW'(w_out[VW-1:2*W]), '0);

      // Zero error: weights must come back bit-exact
      rand_vec(xv); rand_vec(wv);
      run_op(17'd3000, 17'd3000, 17'd4096, xv, wv, 0, 1'b0, 1'b0);
      check_eq("zero_err_w", w_out, wv);
      check_eq("zero_err_delta", VW'(delta), '0);

      // Saturated sigmoid
      rand_vec(xv); rand_vec(wv);
      run_op(17'd0, 17'd4096, 17'd4096, xv, wv, 0, 1'b0, 1'b0);
      check_eq("sat_sig_w", w_out, wv);

      // Weight saturation, positive then negative
      xv = '0; wv = '0;
      xv[W-1:0] = 17'h0FFFF; wv[W-1:0] = 17'h0FFFF;
      run_op(17'd2048, 17'd4096, 17'd4096, xv, wv, 0, 1'b0, 1'b0);
      check_eq("wsat_pos", VW'(w_out[W-1:0]), VW'(17'h0FFFF));
      xv[W-1:0] = 17'h10000; wv[W-1:0] = 17'h10000;
      run_op(17'd2048, 17'd4096, 17'd4096, xv, wv, 0, 1'b0, 1'b0);
      check_eq("wsat_neg", VW'(w_out[W-1:0]), VW'(17'h10000));

      // Stray starts in cycles 3, 10 and the DONE cycle are ignored
      rand_vec(xv); rand_vec(wv);
      run_op(17'd1000, 17'd3500, 17'd2048, xv, wv, 0, 1'b1, 1'b0);

      // Reset in cycle 8 aborts, then a fresh run completes
      rand_vec(xv); rand_vec(wv);
      run_op(17'd2048, 17'd4096, 17'd4096, xv, wv, 8, 1'b0, 1'b0);
      rand_vec(xv); rand_vec(wv);
      run_op(17'd1500, 17'd4000, 17'd4096, xv, wv, 0, 1'b0, 1'b0);

      // Rounding boundary
      rand_vec(xv); rand_vec(wv);
      run_op(17'd2048, 17'd2051, 17'd4096, xv, wv, 0, 1'b0, 1'b0);
`ifdef NEURON_BP_ROUND_EN
      rnd_exp = 17'd1;
`else
      rnd_exp = 17'd0;
`endif
      check_eq("round_delta", VW'(delta), VW'(rnd_exp));

      // Random runs, each started in the first IDLE cycle after the previous DONE
      for (int n = 0; n < 4; n++) begin
         rand_vec(xv); rand_vec(wv);
         run_op(W'($urandom_range(4096)), W'($urandom_range(4096)), W'($urandom_range(8192)),
                xv, wv, 0, 1'b0, (n != 3));
      end

      repeat (4) @(negedge clk);
      check_eq("sb_delta_left", VW'(exp_delta_q.size()), '0);
      check_eq("sb_w_left", VW'(exp_w_q.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
